// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage register for the 5-stage MIPS pipeline.
// Carries payload, PC, countdown T_new, exception code and BD flag across one
// stage boundary, with stall, bubble insertion and exception flush to the
// handler PC. Older exceptions win over ones detected in this stage.
// Optional build macro PIPE_STAGE_STAT_EN adds stall/bubble/flush counters.
module pipe_stage_reg #(
    parameter int          DATA_W     = 128,
    parameter int          TNEW_W     = 2,
    parameter int          TNEW_DEC   = 1,
    parameter int          EXC_W      = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              req,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [EXC_W-1:0]  in_exc_code,
    input  logic              in_is_bd,
    input  logic              stage_exc,
    input  logic [EXC_W-1:0]  stage_exc_code,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [EXC_W-1:0]  out_exc_code,
    output logic              out_has_exc,
    output logic              out_is_bd,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STAT_EN
    ,
    output logic [31:0]       stat_stall_cnt,
    output logic [31:0]       stat_bubble_cnt,
    output logic [31:0]       stat_flush_cnt
`endif
);

    localparam logic [TNEW_W-1:0] TNEW_DEC_V = TNEW_W'(TNEW_DEC);

    // Saturating countdown: unsigned subtract that clamps at zero.
    function automatic logic [TNEW_W-1:0] tnew_dec_sat(input logic [TNEW_W-1:0] t);
        if (int'(t) > TNEW_DEC)
            return t - TNEW_DEC_V;
        return '0;
    endfunction

    // First-exception-wins merge; bubbles never carry an exception.
    function automatic logic [EXC_W-1:0] exc_merge(
        input logic             valid,
        input logic [EXC_W-1:0] older,
        input logic             det,
        input logic [EXC_W-1:0] code
    );
        if (!valid)
            return '0;
        if (older != '0)
            return older;
        if (det)
            return code;
        return '0;
    endfunction

    logic              vld_p1;
    logic [31:0]       pc_p1;
    logic [TNEW_W-1:0] tnew_p1;
    logic [EXC_W-1:0]  exc_p1;
    logic              bd_p1;
    logic [DATA_W-1:0] data_p1;

    // Stage boundary register: reset > req > flush > load > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            pc_p1   <= RESET_PC;
            tnew_p1 <= '0;
            exc_p1  <= '0;
            bd_p1   <= 1'b0;
            data_p1 <= '0;
        end else if (req) begin
            vld_p1  <= 1'b0;
            pc_p1   <= HANDLER_PC;
            tnew_p1 <= '0;
            exc_p1  <= '0;
            bd_p1   <= 1'b0;
            data_p1 <= '0;
        end else if (flush) begin
            // Bubble keeps PC and BD so the architectural PC stays correct.
            vld_p1  <= 1'b0;
            pc_p1   <= in_pc;
            tnew_p1 <= '0;
            exc_p1  <= '0;
            bd_p1   <= in_is_bd;
            data_p1 <= '0;
        end else if (en) begin
            vld_p1  <= in_valid;
            pc_p1   <= in_pc;
            tnew_p1 <= tnew_dec_sat(in_tnew);
            exc_p1  <= exc_merge(in_valid, in_exc_code, stage_exc, stage_exc_code);
            bd_p1   <= in_is_bd;
            data_p1 <= in_data;
        end
    end

    assign out_valid    = vld_p1;
    assign out_pc       = pc_p1;
    assign out_tnew     = tnew_p1;
    assign out_exc_code = exc_p1;
    assign out_has_exc  = |exc_p1;
    assign out_is_bd    = bd_p1;
    assign out_data     = data_p1;

`ifdef PIPE_STAGE_STAT_EN
    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        if (c == 32'hFFFF_FFFF)
            return c;
        return c + 32'd1;
    endfunction

    logic [31:0] stall_cnt_p1;
    logic [31:0] bubble_cnt_p1;
    logic [31:0] flush_cnt_p1;

    // Event counters: each counts only the action that actually took effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_p1  <= '0;
            bubble_cnt_p1 <= '0;
            flush_cnt_p1  <= '0;
        end else if (req) begin
            flush_cnt_p1  <= sat_inc(flush_cnt_p1);
        end else if (flush) begin
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end else if (!en) begin
            stall_cnt_p1  <= sat_inc(stall_cnt_p1);
        end
    end

    assign stat_stall_cnt  = stall_cnt_p1;
    assign stat_bubble_cnt = bubble_cnt_p1;
    assign stat_flush_cnt  = flush_cnt_p1;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage register for the 5-stage MIPS pipeline. It replaces the hand-written per-stage registers (F/D, D/E, E/M, M/W).
- Carries the following through one stage boundary:
  - an opaque payload bus;
  - the PC;
  - a countdown T_new field;
  - the exception code and branch-delay (BD) flag.
- Supports stall, bubble insertion, and exception/interrupt flush to the handler PC.
- Merges a newly detected exception with any older one using a first-exception-wins rule.

Parameters:
- DATA_W, 128, width of the opaque payload (control and data fields packed by the instantiating stage).
- TNEW_W, 2, width of the T_new field.
- TNEW_DEC, 1, amount subtracted from T_new on each load; the result saturates at 0.
- EXC_W, 5, width of the exception code; code 0 means no exception.
- RESET_PC, 32'h0000_0000, out_pc value after reset.
- HANDLER_PC, 32'h0000_4180, out_pc value after an exception flush (req).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  load enable; 0 = stall (hold current contents)
- flush  in  1  insert a bubble at this boundary
- req  in  1  exception/interrupt taken; flush the register to the handler PC
- in_valid  in  1  incoming instruction is real (not a bubble)
- in_pc  in  32  incoming PC
- in_tnew  in  TNEW_W  incoming T_new
- in_exc_code  in  EXC_W  exception code from earlier stages
- in_is_bd  in  1  incoming instruction sits in a delay slot
- stage_exc  in  1  this stage detected an exception this cycle
- stage_exc_code  in  EXC_W  code for stage_exc
- in_data  in  DATA_W  payload
- out_valid  out  1  registered valid
- out_pc  out  32  registered PC
- out_tnew  out  TNEW_W  registered T_new
- out_exc_code  out  EXC_W  registered exception code
- out_has_exc  out  1  combinational OR-reduce of out_exc_code
- out_is_bd  out  1  registered BD flag
- out_data  out  DATA_W  registered payload

Behaviour:
- All state updates occur on the posedge of clk. Latency is 1 cycle. All outputs except out_has_exc are registers.
- Per-cycle priority, highest first: reset > req > flush > en > hold.
- reset:
  - out_valid=0, out_pc=RESET_PC, out_tnew=0, out_exc_code=0, out_is_bd=0, out_data=0.
  - Reset asserted in the middle of a stall or flush still takes effect in that cycle.
- req:
  - Same values as reset, except out_pc=HANDLER_PC.
  - Overrides flush, en and stall.
- flush (and no req):
  - out_valid=0, out_data=0, out_tnew=0, out_exc_code=0.
  - out_pc=in_pc and out_is_bd=in_is_bd, so the macroscopic PC and BD flag stay correct for a bubble.
  - flush wins over en=0: stall-induced bubbles must enter even while upstream is held.
- en=1 (no reset/req/flush):
  - out_valid=in_valid, out_pc=in_pc, out_is_bd=in_is_bd, out_data=in_data.
  - out_tnew = (in_tnew > TNEW_DEC) ? in_tnew-TNEW_DEC : 0. The subtraction is unsigned and never wraps.
  - Exception merge: if in_exc_code!=0, keep in_exc_code; else if stage_exc=1, take stage_exc_code; else 0.
  - If in_valid=0, out_exc_code is forced to 0 and stage_exc is ignored.
- en=0 (hold): every register keeps its value. T_new is not decremented while held.
- stage_exc is sampled only on a load cycle; it is ignored on hold, flush, req and reset cycles.

Optional Feature:
- Macro PIPE_STAGE_STAT_EN.
- When defined, the block adds three outputs:
  - stat_stall_cnt [31:0]: cycles with en=0 and no reset/req/flush.
  - stat_bubble_cnt [31:0]: cycles in which flush takes effect.
  - stat_flush_cnt [31:0]: cycles in which req takes effect.
- All three counters clear on reset and saturate at 32'hFFFF_FFFF.
- When the macro is undefined, these ports and the counter logic do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset then load: reset=1 for 2 cycles → out_pc=0, out_valid=0, all outputs 0. Then en=1, in_pc=32'h3000, in_tnew=2, in_valid=1 → out_pc=32'h3000, out_tnew=1, out_valid=1.
- T_new saturation: in_tnew=0 and in_tnew=1 with en=1 → out_tnew=0 in both cases, with no wrap to 3.
- Stall vs bubble: load in_pc=32'h3004, then en=0 for 3 cycles with changing inputs → outputs unchanged. Then flush=1, en=0, in_pc=32'h3008, in_is_bd=1 → out_valid=0, out_data=0, out_pc=32'h3008, out_is_bd=1.
- Exception flush: req=1 together with flush=1 and en=1 → out_pc=32'h4180, out_valid=0, out_exc_code=0, out_is_bd=0.
- Exception merge: in_exc_code=4 with stage_exc=1, code=12 → out_exc_code=4. Then in_exc_code=0, stage_exc=1, code=12 → out_exc_code=12 and out_has_exc=1. Then in_valid=0 with stage_exc=1 → out_exc_code=0.
- PIPE_STAGE_STAT_EN build: 5 stall cycles, 2 bubbles, 1 req → stall/bubble/flush counts = 5/2/1. After reset, all three counters read 0.
